// File: rtl/iob2axil.sv
// IOb slave to AXI4-Lite master bridge with a single outstanding transaction.
// Optional macro IOB2AXIL_ERR_EN adds iob_err_o for non-OKAY AXI responses.
module iob2axil #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // IOb slave
  input  logic                iob_valid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
`ifdef IOB2AXIL_ERR_EN
  output logic                iob_err_o,
`endif
  // AXI4-Lite write address
  output logic [ADDR_W-1:0]   axil_awaddr_o,
  output logic [2:0]          axil_awprot_o,
  output logic                axil_awvalid_o,
  input  logic                axil_awready_i,
  // AXI4-Lite write data
  output logic [DATA_W-1:0]   axil_wdata_o,
  output logic [DATA_W/8-1:0] axil_wstrb_o,
  output logic                axil_wvalid_o,
  input  logic                axil_wready_i,
  // AXI4-Lite write response
  input  logic [1:0]          axil_bresp_i,
  input  logic                axil_bvalid_i,
  output logic                axil_bready_o,
  // AXI4-Lite read address
  output logic [ADDR_W-1:0]   axil_araddr_o,
  output logic [2:0]          axil_arprot_o,
  output logic                axil_arvalid_o,
  input  logic                axil_arready_i,
  // AXI4-Lite read data
  input  logic [DATA_W-1:0]   axil_rdata_i,
  input  logic [1:0]          axil_rresp_i,
  input  logic                axil_rvalid_i,
  output logic                axil_rready_o
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA} state_t;

  state_t              r_state, w_next;
  logic                r_aw_done, r_w_done;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;

  logic w_accept, w_aw_hs, w_w_hs, w_b_hs, w_r_hs;

  assign w_accept = iob_valid_i & iob_ready_o;
  assign w_aw_hs  = axil_awvalid_o & axil_awready_i;
  assign w_w_hs   = axil_wvalid_o & axil_wready_i;
  assign w_b_hs   = axil_bvalid_i & axil_bready_o;
  assign w_r_hs   = axil_rvalid_i & axil_rready_o;

  // Request fields only change on acceptance, so they stay stable under valid.
  assign axil_awaddr_o = r_addr;
  assign axil_araddr_o = r_addr;
  assign axil_wdata_o  = r_wdata;
  assign axil_wstrb_o  = r_wstrb;
  assign axil_awprot_o = 3'b000;
  assign axil_arprot_o = 3'b000;
  assign iob_rvalid_o  = r_rvalid;
  assign iob_rdata_o   = r_rdata;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_next         = r_state;
    iob_ready_o    = 1'b0;
    axil_awvalid_o = 1'b0;
    axil_wvalid_o  = 1'b0;
    axil_bready_o  = 1'b0;
    axil_arvalid_o = 1'b0;
    axil_rready_o  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Masked by reset so nothing is accepted during the reset cycle.
        iob_ready_o = ~rst_i;
        if (iob_valid_i && !rst_i) w_next = (|iob_wstrb_i) ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        axil_awvalid_o = ~r_aw_done;
        axil_wvalid_o  = ~r_w_done;
        if ((r_aw_done || axil_awready_i) && (r_w_done || axil_wready_i)) w_next = WR_RESP;
      end
      WR_RESP: begin
        axil_bready_o = 1'b1;
        if (axil_bvalid_i) w_next = IDLE;
      end
      RD_REQ: begin
        axil_arvalid_o = 1'b1;
        if (axil_arready_i) w_next = RD_DATA;
      end
      RD_DATA: begin
        axil_rready_o = 1'b1;
        if (axil_rvalid_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef IOB2AXIL_ERR_EN
  logic r_err;
  assign iob_err_o = r_err;
`else
  logic w_unused;
  assign w_unused = ^{axil_bresp_i, axil_rresp_i};
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the request and data registers are cleared too, so outputs are all zero in reset.
      r_state   <= IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
`ifdef IOB2AXIL_ERR_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_state  <= w_next;
      r_rvalid <= 1'b0;
`ifdef IOB2AXIL_ERR_EN
      r_err    <= 1'b0;
`endif
      if (w_accept) begin
        r_addr    <= iob_addr_i;
        r_wdata   <= iob_wdata_i;
        r_wstrb   <= iob_wstrb_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      // Each channel remembers its own handshake so AW and W may complete apart.
      if (r_state == WR_REQ) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
`ifdef IOB2AXIL_ERR_EN
      if (r_state == WR_RESP && w_b_hs) r_err <= (axil_bresp_i != 2'b00);
`endif
      if (r_state == RD_DATA && w_r_hs) begin
        r_rvalid <= 1'b1;
`ifdef IOB2AXIL_ERR_EN
        r_err    <= (axil_rresp_i != 2'b00);
        r_rdata  <= (axil_rresp_i != 2'b00) ? '1 : axil_rdata_i;
`else
        r_rdata  <= axil_rdata_i;
`endif
      end
    end
  end

endmodule

// File: tb/tb_iob2axil.sv
// Directed cycle-by-cycle bench for iob2axil; inputs change and outputs are
// checked 1-2 time units after each rising edge.
module tb_iob2axil;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                iob_valid_i;
  logic [ADDR_W-1:0]   iob_addr_i;
  logic [DATA_W-1:0]   iob_wdata_i;
  logic [DATA_W/8-1:0] iob_wstrb_i;
  logic                iob_ready_o, iob_rvalid_o;
  logic [DATA_W-1:0]   iob_rdata_o;
  logic [ADDR_W-1:0]   axil_awaddr_o, axil_araddr_o;
  logic [2:0]          axil_awprot_o, axil_arprot_o;
  logic                axil_awvalid_o, axil_awready_i;
  logic [DATA_W-1:0]   axil_wdata_o;
  logic [DATA_W/8-1:0] axil_wstrb_o;
  logic                axil_wvalid_o, axil_wready_i;
  logic [1:0]          axil_bresp_i;
  logic                axil_bvalid_i, axil_bready_o;
  logic                axil_arvalid_o, axil_arready_i;
  logic [DATA_W-1:0]   axil_rdata_i;
  logic [1:0]          axil_rresp_i;
  logic                axil_rvalid_i, axil_rready_o;
`ifdef IOB2AXIL_ERR_EN
  logic                iob_err_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  iob2axil #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .iob_valid_i(iob_valid_i), .iob_addr_i(iob_addr_i), .iob_wdata_i(iob_wdata_i),
    .iob_wstrb_i(iob_wstrb_i), .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
    .iob_rdata_o(iob_rdata_o),
`ifdef IOB2AXIL_ERR_EN
    .iob_err_o(iob_err_o),
`endif
    .axil_awaddr_o(axil_awaddr_o), .axil_awprot_o(axil_awprot_o),
    .axil_awvalid_o(axil_awvalid_o), .axil_awready_i(axil_awready_i),
    .axil_wdata_o(axil_wdata_o), .axil_wstrb_o(axil_wstrb_o),
    .axil_wvalid_o(axil_wvalid_o), .axil_wready_i(axil_wready_i),
    .axil_bresp_i(axil_bresp_i), .axil_bvalid_i(axil_bvalid_i), .axil_bready_o(axil_bready_o),
    .axil_araddr_o(axil_araddr_o), .axil_arprot_o(axil_arprot_o),
    .axil_arvalid_o(axil_arvalid_o), .axil_arready_i(axil_arready_i),
    .axil_rdata_i(axil_rdata_i), .axil_rresp_i(axil_rresp_i),
    .axil_rvalid_i(axil_rvalid_i), .axil_rready_o(axil_rready_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    iob_valid_i    = 1'b0;
    iob_addr_i     = '0;
    iob_wdata_i    = '0;
    iob_wstrb_i    = '0;
    axil_awready_i = 1'b0;
    axil_wready_i  = 1'b0;
    axil_bresp_i   = 2'b00;
    axil_bvalid_i  = 1'b0;
    axil_arready_i = 1'b0;
    axil_rdata_i   = '0;
    axil_rresp_i   = 2'b00;
    axil_rvalid_i  = 1'b0;
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_ready"},   iob_ready_o,    0);
    check({tag, "_rvalid"},  iob_rvalid_o,   0);
    check({tag, "_rdata"},   iob_rdata_o,    0);
    check({tag, "_awvalid"}, axil_awvalid_o, 0);
    check({tag, "_wvalid"},  axil_wvalid_o,  0);
    check({tag, "_arvalid"}, axil_arvalid_o, 0);
    check({tag, "_bready"},  axil_bready_o,  0);
    check({tag, "_rready"},  axil_rready_o,  0);
    check({tag, "_awaddr"},  axil_awaddr_o,  0);
    check({tag, "_wdata"},   axil_wdata_o,   0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    tick(); tick();
    settle();
    check_all_low("rst");
    check("rst_awprot", axil_awprot_o, 0);
    check("rst_arprot", axil_arprot_o, 0);
    rst_i = 1'b0;
    settle();
    check("rst_release_ready", iob_ready_o, 1);

    // Zero-wait write: addr 0x10, data A5A5A5A5, strobe F.
    tick();
    iob_valid_i = 1; iob_addr_i = 32'h10; iob_wdata_i = 32'hA5A5_A5A5; iob_wstrb_i = 4'hF;
    axil_awready_i = 1; axil_wready_i = 1;
    settle();
    check("w1_c0_ready", iob_ready_o, 1);
    tick();
    iob_valid_i = 0; settle();
    check("w1_c1_awvalid", axil_awvalid_o, 1);
    check("w1_c1_wvalid",  axil_wvalid_o,  1);
    check("w1_c1_awaddr",  axil_awaddr_o,  32'h10);
    check("w1_c1_wdata",   axil_wdata_o,   32'hA5A5_A5A5);
    check("w1_c1_wstrb",   axil_wstrb_o,   4'hF);
    check("w1_c1_bready",  axil_bready_o,  0);
    check("w1_c1_ready",   iob_ready_o,    0);
    tick();
    axil_bvalid_i = 1; settle();
    check("w1_c2_awvalid", axil_awvalid_o, 0);
    check("w1_c2_wvalid",  axil_wvalid_o,  0);
    check("w1_c2_bready",  axil_bready_o,  1);
    check("w1_c2_rvalid",  iob_rvalid_o,   0);
    tick();
    idle_inputs(); settle();
    check("w1_c3_ready",  iob_ready_o,   1);
    check("w1_c3_bready", axil_bready_o, 0);
    check("w1_c3_rvalid", iob_rvalid_o,  0);

    // Read addr 0x20, rvalid delayed 3 cycles after rready rises.
    tick();
    iob_valid_i = 1; iob_addr_i = 32'h20; iob_wstrb_i = 4'h0; settle();
    check("r1_c0_ready", iob_ready_o, 1);
    tick();
    iob_valid_i = 0; axil_arready_i = 1; settle();
    check("r1_c1_arvalid", axil_arvalid_o, 1);
    check("r1_c1_araddr",  axil_araddr_o,  32'h20);
    check("r1_c1_awvalid", axil_awvalid_o, 0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      axil_arready_i = 0; settle();
      check("r1_wait_rready",  axil_rready_o,  1);
      check("r1_wait_arvalid", axil_arvalid_o, 0);
      check("r1_wait_rvalid",  iob_rvalid_o,   0);
    end
    tick();
    axil_rvalid_i = 1; axil_rdata_i = 32'h1234_5678; settle();
    check("r1_c5_rvalid", iob_rvalid_o, 0);
    tick();
    idle_inputs(); settle();
    check("r1_c6_rvalid", iob_rvalid_o,  1);
    check("r1_c6_rdata",  iob_rdata_o,   32'h1234_5678);
    check("r1_c6_ready",  iob_ready_o,   1);
    check("r1_c6_rready", axil_rready_o, 0);
    tick(); settle();
    check("r1_c7_rvalid", iob_rvalid_o, 0);

    // Write with AW accepted at cycle 1, W only at cycle 4; slave answers SLVERR.
    tick();
    iob_valid_i = 1; iob_addr_i = 32'h30; iob_wdata_i = 32'h0F0F_0F0F; iob_wstrb_i = 4'h1;
    settle();
    check("w2_c0_ready", iob_ready_o, 1);
    tick();
    iob_valid_i = 0; axil_awready_i = 1; settle();
    check("w2_c1_awvalid", axil_awvalid_o, 1);
    check("w2_c1_wvalid",  axil_wvalid_o,  1);
    for (int c = 2; c <= 3; c++) begin
      tick();
      axil_awready_i = 0; settle();
      check("w2_wait_awvalid", axil_awvalid_o, 0);
      check("w2_wait_wvalid",  axil_wvalid_o,  1);
      check("w2_wait_bready",  axil_bready_o,  0);
    end
    tick();
    axil_wready_i = 1; settle();
    check("w2_c4_wvalid", axil_wvalid_o, 1);
    check("w2_c4_wstrb",  axil_wstrb_o,  4'h1);
    check("w2_c4_bready", axil_bready_o, 0);
    tick();
    axil_wready_i = 0; axil_bvalid_i = 1; axil_bresp_i = 2'b10; settle();
    check("w2_c5_wvalid", axil_wvalid_o, 0);
    check("w2_c5_bready", axil_bready_o, 1);
    tick();
    idle_inputs(); settle();
    check("w2_c6_ready",  iob_ready_o,  1);
    check("w2_c6_rvalid", iob_rvalid_o, 0);
`ifdef IOB2AXIL_ERR_EN
    check("w2_c6_err", iob_err_o, 1);
    tick(); settle();
    check("w2_c7_err", iob_err_o, 0);
`endif

    // Reset while waiting in RD_DATA; slave later asserts rvalid.
    tick();
    iob_valid_i = 1; iob_addr_i = 32'h50; iob_wstrb_i = 4'h0; settle();
    tick();
    iob_valid_i = 0; axil_arready_i = 1; settle();
    check("rr_c1_arvalid", axil_arvalid_o, 1);
    tick();
    axil_arready_i = 0; rst_i = 1; settle();
    check("rr_c2_rready", axil_rready_o, 1);
    check("rr_c2_ready",  iob_ready_o,   0);
    tick();
    axil_rvalid_i = 1; axil_rdata_i = 32'hDEAD_BEEF; settle();
    check_all_low("rr_in_rst");
    tick();
    rst_i = 0; settle();
    check("rr_after_rready", axil_rready_o, 0);
    check("rr_after_rvalid", iob_rvalid_o,  0);
    check("rr_after_ready",  iob_ready_o,   1);
    tick();
    idle_inputs(); settle();
    check("rr_late_rvalid", iob_rvalid_o, 0);

    // Zero-wait read answered with SLVERR.
    tick();
    iob_valid_i = 1; iob_addr_i = 32'h60; iob_wstrb_i = 4'h0; settle();
    tick();
    iob_valid_i = 0; axil_arready_i = 1; settle();
    tick();
    axil_arready_i = 0; axil_rvalid_i = 1; axil_rresp_i = 2'b10; axil_rdata_i = 32'h0BAD_F00D;
    settle();
    check("re_c2_rready", axil_rready_o, 1);
    tick();
    idle_inputs(); settle();
    check("re_c3_rvalid", iob_rvalid_o, 1);
    check("re_c3_ready",  iob_ready_o,  1);
`ifdef IOB2AXIL_ERR_EN
    check("re_c3_err",   iob_err_o,   1);
    check("re_c3_rdata", iob_rdata_o, 32'hFFFF_FFFF);
`else
    check("re_c3_rdata", iob_rdata_o, 32'h0BAD_F00D);
`endif

    // Back-to-back: read held, write queued behind it on the same valid.
    tick();
    iob_valid_i = 1; iob_addr_i = 32'h40; iob_wstrb_i = 4'h0; settle();
    check("bb_c0_ready", iob_ready_o, 1);
    tick();
    iob_addr_i = 32'h44; iob_wdata_i = 32'h1122_3344; iob_wstrb_i = 4'h3; axil_arready_i = 1;
    settle();
    check("bb_c1_ready",   iob_ready_o,    0);
    check("bb_c1_arvalid", axil_arvalid_o, 1);
    check("bb_c1_araddr",  axil_araddr_o,  32'h40);
    tick();
    axil_arready_i = 0; axil_rvalid_i = 1; axil_rdata_i = 32'hCAFE_F00D; settle();
    check("bb_c2_ready",   iob_ready_o,    0);
    check("bb_c2_awvalid", axil_awvalid_o, 0);
    tick();
    axil_rvalid_i = 0; settle();
    check("bb_c3_rvalid", iob_rvalid_o, 1);
    check("bb_c3_rdata",  iob_rdata_o,  32'hCAFE_F00D);
    check("bb_c3_ready",  iob_ready_o,  1);
    tick();
    iob_valid_i = 0; axil_awready_i = 1; axil_wready_i = 1; settle();
    check("bb_c4_awvalid", axil_awvalid_o, 1);
    check("bb_c4_wvalid",  axil_wvalid_o,  1);
    check("bb_c4_awaddr",  axil_awaddr_o,  32'h44);
    check("bb_c4_wdata",   axil_wdata_o,   32'h1122_3344);
    check("bb_c4_wstrb",   axil_wstrb_o,   4'h3);
    check("bb_c4_ready",   iob_ready_o,    0);
    tick();
    axil_awready_i = 0; axil_wready_i = 0; axil_bvalid_i = 1; settle();
    check("bb_c5_bready", axil_bready_o, 1);
    tick();
    idle_inputs(); settle();
    check("bb_c6_ready",  iob_ready_o,  1);
    check("bb_c6_rvalid", iob_rvalid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iob2axil.md
IOB2AXIL -- requirements
Module: iob2axil

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both IOb and AXI4-Lite sides.
REQ-002 Parameter DATA_W, default 32, data width of both sides; wstrb width is DATA_W/8.
REQ-003 clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 iob_valid_i / iob_addr_i / iob_wdata_i / iob_wstrb_i  input  1 / ADDR_W / DATA_W / DATA_W/8  IOb slave request; wstrb != 0 means write, wstrb == 0 means read.
REQ-006 iob_ready_o / iob_rvalid_o / iob_rdata_o  output  1 / 1 / DATA_W  IOb slave accept, read-data valid, read data.
REQ-007 axil_awaddr_o, axil_awprot_o(3), axil_awvalid_o, axil_awready_i  AXI-Lite write-address channel, master side.
REQ-008 axil_wdata_o, axil_wstrb_o, axil_wvalid_o, axil_wready_i  AXI-Lite write-data channel, master side.
REQ-009 axil_bresp_i(2), axil_bvalid_i, axil_bready_o  AXI-Lite write-response channel.
REQ-010 axil_araddr_o, axil_arprot_o(3), axil_arvalid_o, axil_arready_i  AXI-Lite read-address channel.
REQ-011 axil_rdata_i, axil_rresp_i(2), axil_rvalid_i, axil_rready_o  AXI-Lite read-data channel.

Function
REQ-012 The block SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA; one outstanding transaction at most.
REQ-013 The block SHALL drive iob_ready_o high only in IDLE; a request is accepted when iob_valid_i and iob_ready_o are both high.
REQ-014 On acceptance, the block SHALL register addr, wdata and wstrb, and enter WR_REQ (wstrb != 0) or RD_REQ (wstrb == 0) on the next edge.
REQ-015 In WR_REQ, the block SHALL assert axil_awvalid_o and axil_wvalid_o together from the first cycle; each valid drops independently after its own handshake; the FSM enters WR_RESP only after both handshakes, including when they occur in different cycles.
REQ-016 In WR_RESP, the block SHALL hold axil_bready_o high and return to IDLE on the cycle after the bvalid handshake; writes produce no iob_rvalid_o.
REQ-017 In RD_REQ, the block SHALL hold axil_arvalid_o high until arready, then enter RD_DATA.
REQ-018 In RD_DATA, the block SHALL hold axil_rready_o high; on the rvalid handshake it SHALL register rdata and return to IDLE; iob_rvalid_o is high for exactly one cycle, the cycle after the handshake, with iob_rdata_o valid in that cycle.
REQ-019 The block SHALL drive axil_awprot_o and axil_arprot_o to 3'b000, and axil_awaddr_o/axil_araddr_o/axil_wdata_o/axil_wstrb_o from the registered request, stable while the corresponding valid is high.
REQ-020 Minimum latency with zero-wait slave: write accept cycle 0, AW/W handshake cycle 1, B handshake cycle 2, iob_ready_o high cycle 3; read accept cycle 0, AR handshake cycle 1, R handshake cycle 2, iob_rvalid_o high cycle 3 together with iob_ready_o.
REQ-021 Without the feature in REQ-025, the block SHALL ignore axil_bresp_i and axil_rresp_i.

Reset
REQ-022 While rst_i is high at a clock edge, the block SHALL enter IDLE and clear iob_rvalid_o, iob_rdata_o, all axil_*valid_o, axil_bready_o, axil_rready_o and the request registers to 0.
REQ-023 iob_ready_o SHALL be 0 during the reset cycle and 1 on the first cycle after rst_i falls.
REQ-024 Reset asserted mid-transaction SHALL abandon it: no iob_rvalid_o is produced, and any later AXI response is ignored because the ready signals are low.

Configuration
REQ-025 With macro IOB2AXIL_ERR_EN defined, the block SHALL add output iob_err_o (1 bit), pulsed with iob_rvalid_o when rresp != OKAY; iob_rdata_o is then forced to all-ones. On a write, iob_err_o pulses for one cycle, the cycle after the B handshake, when bresp != OKAY.
REQ-026 Without IOB2AXIL_ERR_EN, iob_err_o SHALL be absent and the behaviour SHALL be that of REQ-021.

Verification
REQ-027 Write addr 0x10, wdata 0xA5A5A5A5, wstrb 0xF; zero-wait slave -> AW/W presented cycle 1 with those values, bready high cycle 2, iob_ready_o high again cycle 3, no iob_rvalid_o.
REQ-028 Read addr 0x20, slave returns 0x12345678 after 3-cycle rvalid delay -> iob_rvalid_o one-cycle pulse with iob_rdata_o = 0x12345678 the cycle after the R handshake.
REQ-029 Write with awready at cycle 1 and wready delayed to cycle 4 -> awvalid drops after cycle 1, wvalid held until cycle 4, bready not asserted before cycle 5.
REQ-030 rst_i asserted in RD_DATA before rvalid; slave then asserts rvalid -> all outputs 0 during reset, rready low, no iob_rvalid_o, iob_ready_o high the cycle after reset falls.
REQ-031 IOB2AXIL_ERR_EN defined, read with rresp = 2'b10 -> iob_err_o and iob_rvalid_o pulse together, iob_rdata_o = 0xFFFFFFFF.
REQ-032 Back-to-back: iob_valid_i held high with a read, then a write queued -> second request accepted only in the cycle iob_ready_o returns high, never during a transaction.
